// File: rtl/cas_fsk_rx.sv
// cas_fsk_rx: cassette FSK receiver; classifies half-cycles as S/L and deframes start/8 data/stop bytes.
// Define CAS_RX_FILTER_EN to add a FILTER_CYCLES stability filter behind the synchronizer.
module cas_fsk_rx #(
    parameter logic [15:0] MIN_HALF       = 16'd1600,
    parameter logic [15:0] THRESH         = 16'd5000,
    parameter logic [15:0] MAX_HALF       = 16'd10000,
    parameter logic [7:0]  CARRIER_HALVES = 8'd64
`ifdef CAS_RX_FILTER_EN
    ,
    parameter logic [7:0]  FILTER_CYCLES  = 8'd8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       din,
    output logic [7:0] dout,
    output logic       valid,
    output logic       ferr,
    output logic       carrier
);
    typedef enum logic [2:0] {IDLE, CARR, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [1:0] sync;
    logic lvl, lvl_d, acc, is_l;
    logic [15:0] cnt, cnt_n;
    logic [7:0] run, run_n, sh, sh_n, dout_n;
    logic [2:0] hc, hc_n, bi, bi_n;
    logic ht, ht_n;
    logic valid_n, ferr_n;

    always_ff @(posedge clk or posedge reset)
        if (reset) sync <= '0;
        else sync <= {sync[0], din};

`ifdef CAS_RX_FILTER_EN
    logic [7:0] fcnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            fcnt <= '0;
            lvl <= 1'b0;
        end else if (sync[1] == lvl) fcnt <= '0;
        else if (fcnt == FILTER_CYCLES - 8'd1) begin
            fcnt <= '0;
            lvl <= sync[1];
        end else fcnt <= fcnt + 8'd1;
`else
    assign lvl = sync[1];
`endif

    // A too-early edge is dropped without restarting the width measurement.
    assign acc  = (lvl ^ lvl_d) && cnt >= MIN_HALF;
    assign is_l = cnt >= THRESH;

    always_comb begin
        state_n = state;
        cnt_n   = acc ? '0 : (cnt == MAX_HALF ? cnt : cnt + 16'd1);
        run_n   = state == IDLE ? run : '0;
        sh_n    = sh;
        dout_n  = dout;
        hc_n    = hc;
        bi_n    = bi;
        ht_n    = ht;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            run_n   = '0;
            sh_n    = '0;
            hc_n    = '0;
            bi_n    = '0;
            ht_n    = 1'b0;
        end else if (!acc) begin
            if (cnt == MAX_HALF) begin
                state_n = IDLE;
                run_n   = '0;
                ferr_n  = state inside {START, DATA, STOP};
            end
        end else begin
            case (state)
                IDLE: begin
                    run_n = is_l ? '0 : (run == CARRIER_HALVES ? run : run + 8'd1);
                    if (!is_l && run == CARRIER_HALVES - 8'd1) state_n = CARR;
                end
                CARR: state_n = is_l ? START : CARR;
                START: begin
                    state_n = is_l ? DATA : CARR;
                    hc_n    = '0;
                    bi_n    = '0;
                end
                DATA: begin
                    // ht remembers whether this bit is being built from short or long halves.
                    if (hc != 3'd0 && ht != is_l) begin
                        state_n = IDLE;
                        ferr_n  = 1'b1;
                    end else if (hc == (is_l ? 3'd1 : 3'd3)) begin
                        sh_n = {~is_l, sh[7:1]};
                        hc_n = '0;
                        bi_n = bi + 3'd1;
                        if (bi == 3'd7) state_n = STOP;
                    end else begin
                        hc_n = hc + 3'd1;
                        ht_n = is_l;
                    end
                end
                STOP: begin
                    if (is_l) begin
                        state_n = IDLE;
                        ferr_n  = 1'b1;
                    end else if (hc == 3'd3) begin
                        state_n = CARR;
                        dout_n  = sh;
                        valid_n = 1'b1;
                        hc_n    = '0;
                    end else hc_n = hc + 3'd1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= IDLE;
            lvl_d   <= 1'b0;
            cnt     <= '0;
            run     <= '0;
            sh      <= '0;
            dout    <= '0;
            hc      <= '0;
            bi      <= '0;
            ht      <= 1'b0;
            valid   <= 1'b0;
            ferr    <= 1'b0;
            carrier <= 1'b0;
        end else begin
            state   <= state_n;
            lvl_d   <= lvl;
            cnt     <= cnt_n;
            run     <= run_n;
            sh      <= sh_n;
            dout    <= dout_n;
            hc      <= hc_n;
            bi      <= bi_n;
            ht      <= ht_n;
            valid   <= valid_n;
            ferr    <= ferr_n;
            carrier <= state_n != IDLE;
        end
endmodule

// File: tb/tb_cas_fsk_rx.sv
// tb_cas_fsk_rx: randomized frame-level bench for cas_fsk_rx with all timing parameters scaled by 1/100.
// The bench encodes bytes into S/L half sequences and expects the same bytes back.
module tb_cas_fsk_rx;
    localparam int MAX_HALF = 100;
`ifdef CAS_RX_FILTER_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 3;
`endif
    logic clk = 1'b0, reset = 1'b1, en = 1'b1, din = 1'b0;
    logic [7:0] dout, v_dout;
    logic valid, ferr, carrier;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_valid = 0, n_ferr = 0, n_both = 0, v_cyc = 0, f_cyc = 0, last_tog = 0;
    logic [7:0] exp_dout = 8'h00;

    cas_fsk_rx #(.MIN_HALF(16'd16), .THRESH(16'd50), .MAX_HALF(16'd100), .CARRIER_HALVES(8'd64)) dut (
        .clk(clk), .reset(reset), .en(en), .din(din),
        .dout(dout), .valid(valid), .ferr(ferr), .carrier(carrier)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (valid) begin n_valid++; v_cyc = cyc; v_dout = dout; end
        if (ferr) begin n_ferr++; f_cyc = cyc; end
        if (valid && ferr) n_both++;
    end

    task automatic half(input int w);
        repeat (w) @(posedge clk);
        #1 din = ~din;
        last_tog = cyc;
    endtask
    task automatic s_half(); half(int'($urandom_range(34, 18))); endtask
    task automatic l_half(); half(int'($urandom_range(86, 52))); endtask
    task automatic preamble(input int n); repeat (n) s_half(); endtask
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++)
            if (b[i]) repeat (4) s_half();
            else repeat (2) l_half();
    endtask
    task automatic send_frame(input logic [7:0] b);
        l_half(); l_half();
        send_bits(b, 8);
        repeat (4) s_half();
    endtask
    task automatic settle(); repeat (LAT + 2) @(negedge clk); endtask

    task automatic test_reset();
        int v0, f0;
        logic [7:0] b;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        b = 8'($urandom_range(255, 1));
        preamble(64);
        send_frame(b);
        l_half(); l_half();
        send_bits(8'($urandom), 3);
        n_checks++; if (v_dout !== b) begin n_fail++; $display("FAIL pre_reset_byte: got %h want %h", v_dout, b); end
        v0 = n_valid; f0 = n_ferr;
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr); end
        n_checks++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL reset_carrier: got %b want 0", carrier); end
        repeat (63) half(33);
        settle();
        n_checks++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL carrier_after_63: got %b want 0", carrier); end
        half(33 - LAT - 2);
        settle();
        n_checks++; if (carrier !== 1'b1) begin n_fail++; $display("FAIL carrier_after_64: got %b want 1", carrier); end
        n_checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin n_fail++; $display("FAIL reset_no_pulse: got valid %0d ferr %0d want 0 0", n_valid - v0, n_ferr - f0); end
        exp_dout = 8'h00;
    endtask

    task automatic test_byte();
        int v0, f0, t;
        v0 = n_valid; f0 = n_ferr;
        preamble(100);
        send_frame(8'hA5);
        t = last_tog;
        settle();
        n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL byte_valid_count: got %0d want 1", n_valid - v0); end
        n_checks++; if (v_dout !== 8'hA5) begin n_fail++; $display("FAIL byte_dout: got %h want a5", v_dout); end
        n_checks++; if (v_cyc - t !== LAT) begin n_fail++; $display("FAIL byte_latency: got %0d want %0d", v_cyc - t, LAT); end
        preamble(20);
        settle();
        n_checks++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL byte_ferr: got %0d want 0", n_ferr - f0); end
        n_checks++; if (carrier !== 1'b1) begin n_fail++; $display("FAIL byte_carrier: got %b want 1", carrier); end
        exp_dout = 8'hA5;
    endtask

    task automatic test_back_to_back();
        int v0, f0, t;
        logic [7:0] b;
        f0 = n_ferr;
        for (int k = 0; k < 4; k++) begin
            v0 = n_valid;
            b = 8'($urandom);
            preamble(int'($urandom_range(4, 0)));
            send_frame(b);
            t = last_tog;
            settle();
            n_checks++; if (n_valid - v0 !== 1 || v_dout !== b) begin n_fail++; $display("FAIL b2b_byte%0d: got %0d pulses dout %h want 1 pulse dout %h", k, n_valid - v0, v_dout, b); end
            n_checks++; if (v_cyc - t !== LAT) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d want %0d", k, v_cyc - t, LAT); end
            exp_dout = b;
        end
        n_checks++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d want 0", n_ferr - f0); end
    endtask

    task automatic test_stop_err();
        int v0, f0, t;
        v0 = n_valid; f0 = n_ferr;
        preamble(int'($urandom_range(3, 0)));
        l_half(); l_half();
        send_bits(8'h3C, 8);
        l_half();
        t = last_tog;
        l_half();
        settle();
        n_checks++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL stop_ferr_count: got %0d want 1", n_ferr - f0); end
        n_checks++; if (f_cyc - t !== LAT) begin n_fail++; $display("FAIL stop_ferr_latency: got %0d want %0d", f_cyc - t, LAT); end
        n_checks++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL stop_valid: got %0d want 0", n_valid - v0); end
        n_checks++; if (dout !== exp_dout) begin n_fail++; $display("FAIL stop_dout: got %h want %h", dout, exp_dout); end
        n_checks++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL stop_carrier: got %b want 0", carrier); end
    endtask

    task automatic test_timeout();
        int v0, f0, t;
        logic [7:0] b;
        v0 = n_valid; f0 = n_ferr;
        preamble(64);
        settle();
        n_checks++; if (carrier !== 1'b1) begin n_fail++; $display("FAIL to_carrier_up: got %b want 1", carrier); end
        l_half(); l_half();
        send_bits(8'($urandom), 3);
        t = last_tog;
        repeat (MAX_HALF + LAT + 20) @(negedge clk);
        n_checks++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL to_ferr_count: got %0d want 1", n_ferr - f0); end
        n_checks++; if (f_cyc - t !== MAX_HALF + 1 + LAT) begin n_fail++; $display("FAIL to_ferr_time: got %0d want %0d", f_cyc - t, MAX_HALF + 1 + LAT); end
        n_checks++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL to_carrier_down: got %b want 0", carrier); end
        half(60);
        preamble(63);
        settle();
        n_checks++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL to_carrier_63: got %b want 0", carrier); end
        s_half();
        settle();
        n_checks++; if (carrier !== 1'b1) begin n_fail++; $display("FAIL to_carrier_64: got %b want 1", carrier); end
        b = 8'($urandom);
        send_frame(b);
        settle();
        n_checks++; if (n_valid - v0 !== 1 || v_dout !== b) begin n_fail++; $display("FAIL to_next_byte: got %0d pulses dout %h want 1 pulse dout %h", n_valid - v0, v_dout, b); end
        exp_dout = b;
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        l_half(); l_half();
        send_bits(8'h3C, 2);
        half(8); half(2); half(24);
        repeat (3) s_half();
        send_bits(8'h3C >> 3, 5);
        repeat (4) s_half();
        settle();
        n_checks++; if (n_valid - v0 !== 1 || v_dout !== 8'h3C) begin n_fail++; $display("FAIL glitch_byte: got %0d pulses dout %h want 1 pulse dout 3c", n_valid - v0, v_dout); end
        n_checks++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
        exp_dout = 8'h3C;
    endtask

    task automatic test_en();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        l_half(); l_half();
        send_bits(8'h5A, 2);
        @(posedge clk); #1 en = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL en_carrier: got %b want 0", carrier); end
        n_checks++; if (dout !== exp_dout) begin n_fail++; $display("FAIL en_dout_kept: got %h want %h", dout, exp_dout); end
        en = 1'b1;
        n_checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin n_fail++; $display("FAIL en_abort_pulse: got valid %0d ferr %0d want 0 0", n_valid - v0, n_ferr - f0); end
        preamble(64);
        send_frame(8'h5A);
        settle();
        n_checks++; if (n_valid - v0 !== 1 || v_dout !== 8'h5A) begin n_fail++; $display("FAIL en_replay: got %0d pulses dout %h want 1 pulse dout 5a", n_valid - v0, v_dout); end
        n_checks++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL en_ferr: got %0d want 0", n_ferr - f0); end
        exp_dout = 8'h5A;
    endtask

`ifdef CAS_RX_FILTER_EN
    task automatic test_filter();
        int v0, f0;
        logic [7:0] b;
        v0 = n_valid; f0 = n_ferr;
        b = 8'($urandom) & 8'hFE;
        l_half(); l_half();
        half(25); half(5); half(40);
        l_half();
        send_bits(b >> 1, 7);
        repeat (4) s_half();
        settle();
        n_checks++; if (n_valid - v0 !== 1 || v_dout !== b) begin n_fail++; $display("FAIL filter_byte: got %0d pulses dout %h want 1 pulse dout %h", n_valid - v0, v_dout, b); end
        n_checks++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL filter_ferr: got %0d want 0", n_ferr - f0); end
        exp_dout = b;
    endtask
`endif

    initial begin
        test_reset();
        test_byte();
        test_back_to_back();
        test_stop_err();
        test_timeout();
        test_glitch();
        test_en();
`ifdef CAS_RX_FILTER_EN
        test_filter();
`endif
        n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL valid_ferr_overlap: got %0d want 0", n_both); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
